// File: rtl/mod_segment_swapchain.sv
// rtl/mod_segment_swapchain.sv - modulation segment selection, transition and loop control
//
// Purpose: consumes the controller's modulation settings record and decides
// which BRAM segment the modulation reader plays and when it changes. It
// applies the transition condition, counts loops against the repeat count
// and halts finite playback.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   UPDATE               one-cycle pulse, settings record valid
//   REQ_RD_SEGMENT       requested segment
//   TRANSITION_MODE      transition condition code
//   TRANSITION_VALUE     mode argument (time threshold or GPIO select)
//   CYCLE0, CYCLE1       last sample index of segment 0/1
//   REP0, REP1           repeat counts, all ones = infinite
//   SYS_TIME             synchronized system time
//   GPIO_IN              synchronized trigger lines
//   IDX_VALID, IDX       index advance pulse and current sample index
//   SEGMENT              active segment
//   STOP                 playback halted
//   IDX_RST              index timer restart pulse
//   PENDING              transition request waiting
//   LOOP_CNT             completed loops of the active segment
module mod_segment_swapchain #(
  parameter int CYCLE_W = 15,
  parameter int GPIO_W  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               UPDATE,
  input  logic               REQ_RD_SEGMENT,
  input  logic [7:0]         TRANSITION_MODE,
  input  logic [63:0]        TRANSITION_VALUE,
  input  logic [CYCLE_W-1:0] CYCLE0,
  input  logic [CYCLE_W-1:0] CYCLE1,
  input  logic [31:0]        REP0,
  input  logic [31:0]        REP1,
  input  logic [63:0]        SYS_TIME,
  input  logic [GPIO_W-1:0]  GPIO_IN,
  input  logic               IDX_VALID,
  input  logic [CYCLE_W-1:0] IDX,
  output logic               SEGMENT,
  output logic               STOP,
  output logic               IDX_RST,
  output logic               PENDING,
  output logic [31:0]        LOOP_CNT
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME = 8'h01;
  localparam logic [7:0] MODE_GPIO     = 8'h02;
  localparam logic [7:0] MODE_EXT      = 8'hF0;

  localparam logic [31:0] REP_INF = 32'hFFFF_FFFF;

  logic [1:0]         state;
  logic               upd_hold;
  logic               sh_req;
  logic [7:0]         sh_mode;
  logic [63:0]        sh_value;
  logic [CYCLE_W-1:0] sh_cycle0;
  logic [CYCLE_W-1:0] sh_cycle1;
  logic [31:0]        sh_rep0;
  logic [31:0]        sh_rep1;
  logic [GPIO_W-1:0]  gpio_prev;

  logic               req_go;
  logic               req_seg;
  logic [31:0]        req_rep;
  logic [CYCLE_W-1:0] cur_cycle;
  logic [31:0]        cur_rep;
  logic               loop_end;
  logic [GPIO_W-1:0]  gpio_rise;
  logic               fire;
  logic               do_switch;
  logic               switch_seg;
  logic               go_wait;
  logic               go_halt;
  logic               cnt_inc;

  always_comb begin
    // A request is either a live UPDATE or one that arrived during SWITCH;
    // the held one was already snapshotted, so it reads the shadow copy.
    req_go  = (state != ST_SWITCH) && (UPDATE || upd_hold);
    req_seg = UPDATE ? REQ_RD_SEGMENT : sh_req;
    if (UPDATE) begin
      req_rep = REQ_RD_SEGMENT ? REP1 : REP0;
    end else begin
      req_rep = sh_req ? sh_rep1 : sh_rep0;
    end

    cur_cycle = SEGMENT ? sh_cycle1 : sh_cycle0;
    cur_rep   = SEGMENT ? sh_rep1 : sh_rep0;
    loop_end  = IDX_VALID && (IDX == cur_cycle);
    gpio_rise = GPIO_IN & ~gpio_prev;

    case (sh_mode)
      MODE_SYNC_IDX, MODE_EXT: fire = IDX_VALID && (IDX == '0);
      MODE_SYS_TIME:           fire = (SYS_TIME >= sh_value);
      MODE_GPIO:               fire = gpio_rise[sh_value[1:0]];
      default:                 fire = 1'b1;
    endcase

    do_switch  = 1'b0;
    switch_seg = SEGMENT;
    go_wait    = 1'b0;
    go_halt    = 1'b0;
    cnt_inc    = 1'b0;

    if (state != ST_SWITCH) begin
      if (req_go) begin
        // A new request overrides any pending condition that fires now.
        if (req_rep == REP_INF) begin
          do_switch  = 1'b1;
          switch_seg = req_seg;
        end else begin
          go_wait = 1'b1;
          cnt_inc = loop_end && (state != ST_HALT);
        end
      end else if ((state == ST_WAIT) && fire) begin
        // Transition beats a coincident loop end: the count is cleared.
        do_switch  = 1'b1;
        switch_seg = sh_req;
      end else if ((state != ST_HALT) && loop_end) begin
        if ((state == ST_RUN) && (cur_rep != REP_INF) && (LOOP_CNT == cur_rep)) begin
          if (sh_mode == MODE_EXT) begin
            do_switch  = 1'b1;
            switch_seg = ~SEGMENT;
          end else begin
            go_halt = 1'b1;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_RUN;
      upd_hold  <= 1'b0;
      sh_req    <= 1'b0;
      sh_mode   <= 8'h00;
      sh_value  <= 64'd0;
      sh_cycle0 <= '0;
      sh_cycle1 <= '0;
      sh_rep0   <= REP_INF;  // segment 0 plays forever until told otherwise
      sh_rep1   <= 32'd0;
      gpio_prev <= '0;
      SEGMENT   <= 1'b0;
      STOP      <= 1'b0;
      IDX_RST   <= 1'b0;
      PENDING   <= 1'b0;
      LOOP_CNT  <= 32'd0;
    end else begin
      gpio_prev <= GPIO_IN;
      IDX_RST   <= 1'b0;
      upd_hold  <= UPDATE && (state == ST_SWITCH);

      if (UPDATE) begin
        sh_req    <= REQ_RD_SEGMENT;
        sh_mode   <= TRANSITION_MODE;
        sh_value  <= TRANSITION_VALUE;
        sh_cycle0 <= CYCLE0;
        sh_cycle1 <= CYCLE1;
        sh_rep0   <= REP0;
        sh_rep1   <= REP1;
      end

      if (cnt_inc && (LOOP_CNT != REP_INF)) begin
        LOOP_CNT <= LOOP_CNT + 32'd1;
      end

      if (do_switch) begin
        state    <= ST_SWITCH;
        SEGMENT  <= switch_seg;
        LOOP_CNT <= 32'd0;
        STOP     <= 1'b0;
        PENDING  <= 1'b0;
        IDX_RST  <= 1'b1;
      end else if (go_wait) begin
        state   <= ST_WAIT;
        PENDING <= 1'b1;
      end else if (go_halt) begin
        state <= ST_HALT;
        STOP  <= 1'b1;
      end else if (state == ST_SWITCH) begin
        state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_mod_segment_swapchain.sv
// tb/tb_mod_segment_swapchain.sv - directed bench with switch-event scoreboard for mod_segment_swapchain
module tb_mod_segment_swapchain;

  localparam logic [31:0] INF = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        UPDATE = 1'b0;
  logic        REQ_RD_SEGMENT = 1'b0;
  logic [7:0]  TRANSITION_MODE = 8'h00;
  logic [63:0] TRANSITION_VALUE = 64'd0;
  logic [14:0] CYCLE0 = 15'd0;
  logic [14:0] CYCLE1 = 15'd0;
  logic [31:0] REP0 = 32'd0;
  logic [31:0] REP1 = 32'd0;
  logic [63:0] SYS_TIME = 64'd0;
  logic [3:0]  GPIO_IN = 4'd0;
  logic        IDX_VALID = 1'b0;
  logic [14:0] IDX = 15'd0;
  logic        SEGMENT;
  logic        STOP;
  logic        IDX_RST;
  logic        PENDING;
  logic [31:0] LOOP_CNT;

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic        seg;
    int unsigned at;
  } exp_t;
  exp_t sbq[$];

  mod_segment_swapchain #(.CYCLE_W(15), .GPIO_W(4)) dut (
    .CLK(CLK), .RST(RST), .UPDATE(UPDATE), .REQ_RD_SEGMENT(REQ_RD_SEGMENT),
    .TRANSITION_MODE(TRANSITION_MODE), .TRANSITION_VALUE(TRANSITION_VALUE),
    .CYCLE0(CYCLE0), .CYCLE1(CYCLE1), .REP0(REP0), .REP1(REP1),
    .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN), .IDX_VALID(IDX_VALID), .IDX(IDX),
    .SEGMENT(SEGMENT), .STOP(STOP), .IDX_RST(IDX_RST), .PENDING(PENDING),
    .LOOP_CNT(LOOP_CNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic seg, input int unsigned at);
    exp_t e;
    e.seg = seg;
    e.at  = at;
    sbq.push_back(e);
  endtask

  task automatic upd(input logic req, input logic [7:0] mode, input logic [63:0] val,
                     input logic [14:0] c0, input logic [14:0] c1,
                     input logic [31:0] r0, input logic [31:0] r1);
    REQ_RD_SEGMENT   = req;
    TRANSITION_MODE  = mode;
    TRANSITION_VALUE = val;
    CYCLE0 = c0;
    CYCLE1 = c1;
    REP0   = r0;
    REP1   = r1;
    UPDATE = 1'b1;
    tick();
    UPDATE = 1'b0;
  endtask

  task automatic idx_pulse(input logic [14:0] v);
    IDX_VALID = 1'b1;
    IDX = v;
    tick();
    IDX_VALID = 1'b0;
  endtask

  // Every IDX_RST pulse must match the next expected switch event.
  always @(negedge CLK) begin
    if (!RST && IDX_RST) begin
      check("sb_event_expected", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_segment", SEGMENT, e.seg);
        check("sb_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    logic exp_seg;

    // Reset state
    tick();
    tick();
    RST = 1'b0;
    check("rst_segment", SEGMENT, 0);
    check("rst_stop", STOP, 0);
    check("rst_idx_rst", IDX_RST, 0);
    check("rst_pending", PENDING, 0);
    check("rst_loop_cnt", LOOP_CNT, 0);

    // Infinite request switches one cycle after UPDATE, never pends
    push(1'b1, cyc + 1);
    upd(1'b1, 8'h00, 64'd0, 15'd3, 15'd3, INF, INF);
    check("inf_segment", SEGMENT, 1);
    check("inf_idx_rst", IDX_RST, 1);
    check("inf_pending", PENDING, 0);
    tick();
    check("inf_idx_rst_one_cycle", IDX_RST, 0);
    check("inf_pending_after", PENDING, 0);

    // Same-segment request still restarts the index and clears the count
    idx_pulse(15'd3);
    check("same_cnt_before", LOOP_CNT, 1);
    push(1'b1, cyc + 1);
    upd(1'b1, 8'h00, 64'd0, 15'd3, 15'd3, INF, INF);
    check("same_segment", SEGMENT, 1);
    check("same_cnt_cleared", LOOP_CNT, 0);
    tick();

    // Back to segment 0, then SYNC_IDX request to finite segment 1
    push(1'b0, cyc + 1);
    upd(1'b0, 8'hFF, 64'd0, 15'd3, 15'd3, INF, INF);
    tick();
    upd(1'b1, 8'h00, 64'd0, 15'd3, 15'd2, INF, 32'd1);
    check("sync_pending", PENDING, 1);
    idx_pulse(15'd1);
    idx_pulse(15'd2);
    idx_pulse(15'd3);
    check("sync_still_pending", PENDING, 1);
    check("sync_seg0_loop", LOOP_CNT, 1);
    check("sync_segment_hold", SEGMENT, 0);
    push(1'b1, cyc + 1);
    idx_pulse(15'd0);
    check("sync_switched", SEGMENT, 1);
    check("sync_pending_clr", PENDING, 0);
    check("sync_cnt_clr", LOOP_CNT, 0);
    idx_pulse(15'd1);
    idx_pulse(15'd2);
    check("fin_loop1", LOOP_CNT, 1);
    check("fin_not_stopped", STOP, 0);
    idx_pulse(15'd0);
    idx_pulse(15'd1);
    idx_pulse(15'd2);
    check("fin_stop", STOP, 1);
    check("fin_cnt", LOOP_CNT, 1);
    idx_pulse(15'd0);
    idx_pulse(15'd1);
    idx_pulse(15'd2);
    check("halt_stop", STOP, 1);
    check("halt_cnt_frozen", LOOP_CNT, 1);

    // SYS_TIME threshold leaves HALT
    upd(1'b0, 8'h01, 64'd1000, 15'd3, 15'd3, 32'd5, INF);
    check("time_pending", PENDING, 1);
    for (int t = 990; t <= 1003; t++) begin
      SYS_TIME = 64'(t);
      if (t == 1000) push(1'b0, cyc + 1);
      tick();
      check("time_segment", SEGMENT, (t >= 1000) ? 0 : 1);
    end
    check("time_stop_clr", STOP, 0);
    SYS_TIME = 64'd0;

    // GPIO: only a rising edge on the selected line fires
    upd(1'b1, 8'h02, 64'd2, 15'd3, 15'd3, INF, 32'd7);
    GPIO_IN = 4'b0010;
    tick();
    GPIO_IN = 4'b0000;
    tick();
    check("gpio_wrong_line", SEGMENT, 0);
    check("gpio_pending", PENDING, 1);
    GPIO_IN = 4'b0100;
    push(1'b1, cyc + 1);
    tick();
    check("gpio_switch", SEGMENT, 1);
    GPIO_IN = 4'b0000;
    tick();

    // EXT ping-pong with zero repeats
    upd(1'b0, 8'hF0, 64'd0, 15'd1, 15'd1, 32'd0, 32'd0);
    check("ext_pending", PENDING, 1);
    push(1'b0, cyc + 1);
    idx_pulse(15'd0);
    exp_seg = 1'b0;
    check("ext_first", SEGMENT, exp_seg);
    for (int i = 0; i < 6; i++) begin
      idx_pulse(15'd0);
      exp_seg = ~exp_seg;
      push(exp_seg, cyc + 1);
      idx_pulse(15'd1);
      check("ext_alternate", SEGMENT, exp_seg);
      check("ext_no_stop", STOP, 0);
    end

    // UPDATE landing in SWITCH is held and processed one cycle later
    upd(1'b1, 8'h00, 64'd0, 15'd3, 15'd3, INF, 32'd2);
    check("hold_not_yet", PENDING, 0);
    tick();
    check("hold_processed", PENDING, 1);

    // Collision: new IMMEDIATE request beats the old SYNC_IDX fire
    IDX_VALID = 1'b1;
    IDX = 15'd0;
    push(1'b0, cyc + 2);
    upd(1'b0, 8'hFF, 64'd0, 15'd3, 15'd3, 32'd2, 32'd2);
    IDX_VALID = 1'b0;
    check("coll_segment", SEGMENT, 0);
    check("coll_no_switch", IDX_RST, 0);
    check("coll_pending", PENDING, 1);
    tick();
    check("coll_final_seg", SEGMENT, 0);
    check("coll_idx_rst", IDX_RST, 1);
    tick();

    // Reset in the middle of WAIT drops the request
    push(1'b1, cyc + 1);
    upd(1'b1, 8'hFF, 64'd0, 15'd3, 15'd3, 32'd2, INF);
    tick();
    upd(1'b0, 8'h00, 64'd0, 15'd3, 15'd3, 32'd2, INF);
    check("rstw_pending", PENDING, 1);
    check("rstw_seg_before", SEGMENT, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rstw_pending_clr", PENDING, 0);
    check("rstw_segment", SEGMENT, 0);
    check("rstw_loop_cnt", LOOP_CNT, 0);
    idx_pulse(15'd0);
    tick();
    check("rstw_no_switch", SEGMENT, 0);
    check("rstw_no_pending", PENDING, 0);

    tick();
    check("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_segment_swapchain.md
Name: mod_segment_swapchain

Overview:
- Consumer of the modulation settings record (UPDATE, REQ_RD_SEGMENT, TRANSITION_MODE, TRANSITION_VALUE, CYCLE[2], REP[2]) that the controller publishes.
- Decides which modulation BRAM segment the modulation reader uses, and when.
- Applies the requested transition condition, counts completed loops against REP, and stops finite playback.
- Sits between the controller's settings output and the modulation sampler/index timer.

Parameters:
- CYCLE_W, 15, width of CYCLE/IDX.
- GPIO_W, 4, number of GPIO trigger inputs.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- UPDATE  in  1  one-cycle pulse: settings record valid.
- REQ_RD_SEGMENT  in  1  requested segment.
- TRANSITION_MODE  in  8  transition condition code.
- TRANSITION_VALUE  in  64  mode argument.
- CYCLE0, CYCLE1  in  CYCLE_W each  last index of segment 0/1.
- REP0, REP1  in  32 each  repeat count; 0xFFFFFFFF = infinite.
- SYS_TIME  in  64  synchronized system time.
- GPIO_IN  in  GPIO_W  external trigger lines, already synchronized.
- IDX_VALID  in  1  pulse: IDX advanced.
- IDX  in  CYCLE_W  current sample index.
- SEGMENT  out  1  active segment.
- STOP  out  1  playback halted; reader holds last sample.
- IDX_RST  out  1  pulse: index timer restarts at 0.
- PENDING  out  1  transition request waiting.
- LOOP_CNT  out  32  completed loops of active segment.

Behaviour:
- Reset values: SEGMENT=0, STOP=0, IDX_RST=0, PENDING=0, LOOP_CNT=0, state RUN.
  - After reset, segment 0 is treated as infinite.
- UPDATE takes a snapshot of all settings inputs into a shadow register.
- State RUN:
  - On UPDATE with REP[REQ] infinite → SWITCH next cycle; mode is ignored.
  - On UPDATE with REP[REQ] finite → WAIT.
  - Loop end is IDX_VALID && IDX==CYCLE[SEGMENT]; each loop end increments LOOP_CNT, saturating at 0xFFFFFFFF.
  - If the active segment is finite and a loop end occurs while LOOP_CNT==REP[SEGMENT]:
    - mode EXT (0xF0): → SWITCH to ~SEGMENT.
    - any other mode: STOP=1 → HALT.
- State WAIT (PENDING=1): evaluated every cycle against the latched mode.
  - 0x00 SYNC_IDX: fires on IDX_VALID && IDX==0.
  - 0x01 SYS_TIME: fires when SYS_TIME >= TRANSITION_VALUE (unsigned).
  - 0x02 GPIO: fires on rising edge of GPIO_IN[TRANSITION_VALUE[1:0]]. Edge detect uses a 1-cycle delayed copy; the first cycle after reset sees prior=0.
  - 0xF0 EXT: same as SYNC_IDX.
  - 0xFF IMMEDIATE, and any undefined code: fires the cycle after entering WAIT.
  - On fire → SWITCH.
- State SWITCH (single cycle):
  - SEGMENT←requested, LOOP_CNT←0, STOP←0, PENDING←0, IDX_RST=1 for exactly this cycle.
  - → RUN.
  - Latency: condition true at cycle t → SEGMENT/IDX_RST visible at t+1.
- State HALT: STOP=1 and LOOP_CNT frozen. Only UPDATE leaves HALT, with the same handling as in RUN.
- UPDATE with REQ == current SEGMENT: still passes through SWITCH. IDX_RST pulses, LOOP_CNT resets, SEGMENT is unchanged.
- UPDATE during WAIT: the new request replaces the pending one.
  - The condition is re-armed; GPIO edge history is kept.
  - If the old condition fires in the same cycle as the UPDATE, the UPDATE wins and the old transition is discarded.
- UPDATE during SWITCH: the SWITCH completes, then the new request is processed from RUN on the next cycle. UPDATE is held one cycle internally and never dropped.
- Loop end in the same cycle as a WAIT fire: the transition wins. LOOP_CNT is reset, not incremented.
- RST asserted mid-operation: all state returns to reset values on the next edge; a pending request is lost.

Test Plan:
- Infinite switch: RUN seg0, UPDATE REQ=1 REP1=0xFFFFFFFF mode=0x00 → SEGMENT=1 and IDX_RST one cycle after UPDATE; PENDING never 1.
- SYNC_IDX finite: CYCLE0=3, UPDATE REQ=1 REP1=1 mode=0x00 → PENDING=1 until IDX_VALID&IDX==0, switch next cycle.
  - Then after 2 loop ends of CYCLE1: STOP=1, LOOP_CNT=1 frozen.
- SYS_TIME: TRANSITION_VALUE=1000, SYS_TIME ramps from 990 → SEGMENT changes in the cycle after SYS_TIME=1000.
- GPIO: mode=0x02 value=2; pulse GPIO_IN[1] → no switch; rising GPIO_IN[2] → switch one cycle later.
- EXT ping-pong: REP0=REP1=0, mode=0xF0 → SEGMENT alternates after every loop, STOP stays 0.
- Collision/reset: UPDATE(REQ=0, IMMEDIATE) in the same cycle as the pending SYNC_IDX fire → final SEGMENT=0; RST mid-WAIT → PENDING=0, SEGMENT=0 next cycle.
